kamus_mem: RTL and testbench
============================

KAMUS_MEM -- requirements
Module: kamus_mem

Interface
REQ-001 Parameter BUS_TIMEOUT, default 255: max cycles a memory access may spend in REQ+RESP before abort.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 valid_i  in  1  EX-MEM payload valid this cycle.
REQ-005 operation_i  in  6  decoded operation from EX (kamus_pkg encoding).
REQ-006 ex_i  in  32  EX result (effective address for loads/stores).
REQ-007 rs2_data_i  in  32  store data; rd_addr_i  in  5; next_pc_i  in  32; wb_mux_sel_i  in  2; l1d_wr_en_i  in  1; regfile_wr_en_i  in  1.
REQ-008 stall_o  out  1  stage busy; upstream holds its payload.
REQ-009 dmem_req_o out 1; dmem_we_o out 1; dmem_addr_o out 32 (word-aligned); dmem_be_o out 4; dmem_wdata_o out 32.
REQ-010 dmem_gnt_i in 1; dmem_rvalid_i in 1; dmem_rdata_i in 32; dmem_err_i in 1 (qualified by rvalid).
REQ-011 wb_valid_o out 1; wb_ex_o out 32; wb_load_data_o out 32; wb_rd_addr_o out 5; wb_next_pc_o out 32; wb_mux_sel_o out 2; wb_regfile_wr_en_o out 1; exc_misaligned_o out 1; exc_bus_err_o out 1.

Function
REQ-012 Capture payload into stage register when valid_i=1 and stall_o=0.
REQ-013 FSM states IDLE, REQ, RESP; stall_o=1 whenever state!=IDLE.
REQ-014 Non-memory op: wb_valid_o=1 exactly the cycle after capture; throughput one per cycle.
REQ-015 Aligned load/store: IDLE->REQ at capture; dmem_req_o=1 in REQ with addr/be/wdata/we stable until dmem_gnt_i.
REQ-016 REQ + gnt -> RESP; RESP + rvalid -> IDLE, wb_valid_o=1 next cycle.
REQ-017 gnt and rvalid in same cycle: REQ -> IDLE directly, completion as REQ-016.
REQ-018 rvalid in IDLE or REQ without prior gnt ignored.
REQ-019 dmem_we_o = captured l1d_wr_en_i; dmem_addr_o = {ex[31:2],2'b00}.
REQ-020 Byte enables: SW 1111; SH 0011<<addr[1:0]; SB 0001<<addr[1:0]; loads 1111.
REQ-021 Write data: SW rs2; SH {2{rs2[15:0]}}; SB {4{rs2[7:0]}}.
REQ-022 Load data: rdata >> 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; registered on rvalid.
REQ-023 Misaligned (LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0): no request, stays IDLE, wb_valid_o+exc_misaligned_o next cycle, wb_regfile_wr_en_o=0.
REQ-024 rvalid with dmem_err_i=1: completion with exc_bus_err_o=1, wb_regfile_wr_en_o=0.
REQ-025 Timeout counter clears on leaving IDLE; reaching BUS_TIMEOUT cycles in REQ/RESP: drop req, go IDLE, complete with exc_bus_err_o=1, regfile write suppressed; late rvalid ignored.
REQ-026 exc_* outputs valid only with wb_valid_o; otherwise 0.
REQ-027 Other wb_* outputs pass captured fields unchanged.

Reset
REQ-028 rst_ni low: state IDLE, stage valid 0, counter 0 immediately, mid-transaction included.
REQ-029 Reset values: stall_o 0, dmem_req_o 0, dmem_we_o 0, dmem_be_o 0, wb_valid_o 0, wb_regfile_wr_en_o 0, exc_* 0, all data outputs 0.

Structure
REQ-030 kamus_pkg holds operation encodings, mem_state_e, wb_mux_sel encodings, load/store classification helpers.
REQ-031 Sub-module kamus_load_align: combinational byte/half extraction and extension.

Verification
REQ-032 ADD, ex_i=0x1234 -> wb_valid_o next cycle, wb_ex_o=0x1234, no dmem_req_o.
REQ-033 SB addr 0x103, rs2=0xAB, gnt after 2 cycles, rvalid +1 -> be=1000, wdata=0xABABABAB, addr 0x100, stall_o high 4 cycles.
REQ-034 LH addr 0x102, rdata=0x8001_0000, gnt+rvalid same cycle -> wb_load_data_o=0xFFFF8001; LHU -> 0x00008001.
REQ-035 LW addr 0x101 -> no request, exc_misaligned_o=1, wb_regfile_wr_en_o=0.
REQ-036 LW, gnt, no rvalid for BUS_TIMEOUT=4 -> exc_bus_err_o=1 at 4th cycle completion; later rvalid ignored.
REQ-037 rst_ni asserted in RESP -> all outputs at reset values; next LW completes normally.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared definitions for the KAMUS memory stage: operation codes, FSM states,
// write-back mux selects and load/store classification helpers.
package kamus_pkg;

    typedef enum logic [5:0] {
        OP_NOP    = 6'h00,
        OP_ADD    = 6'h01,
        OP_SUB    = 6'h02,
        OP_AND    = 6'h03,
        OP_OR     = 6'h04,
        OP_XOR    = 6'h05,
        OP_SLL    = 6'h06,
        OP_SRL    = 6'h07,
        OP_SRA    = 6'h08,
        OP_SLT    = 6'h09,
        OP_SLTU   = 6'h0A,
        OP_LUI    = 6'h0B,
        OP_AUIPC  = 6'h0C,
        OP_JAL    = 6'h0D,
        OP_JALR   = 6'h0E,
        OP_BRANCH = 6'h0F,
        OP_LB     = 6'h20,
        OP_LH     = 6'h21,
        OP_LW     = 6'h22,
        OP_LBU    = 6'h23,
        OP_LHU    = 6'h24,
        OP_SB     = 6'h28,
        OP_SH     = 6'h29,
        OP_SW     = 6'h2A
    } operation_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam logic [1:0] WB_SEL_EX   = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC   = 2'd2;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_LW, OP_SW:         return addr_lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return addr_lo[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Non-memory operations get no byte lanes so an idle bus never looks like a write.
    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] addr_lo);
        case (op)
            OP_SB:                                      return 4'b0001 << addr_lo;
            OP_SH:                                      return 4'b0011 << addr_lo;
            OP_SW, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 4'b1111;
            default:                                    return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] rs2);
        case (op)
            OP_SB:   return {4{rs2[7:0]}};
            OP_SH:   return {2{rs2[15:0]}};
            default: return rs2;
        endcase
    endfunction

endpackage

// File: rtl/kamus_load_align.sv
// Extracts the addressed byte/half/word from a read beat and sign- or
// zero-extends it according to the load flavour.
module kamus_load_align
    import kamus_pkg::*;
(
    input  logic [5:0]  operation,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (operation)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h000000, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0000, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/kamus_mem.sv
// KAMUS memory stage: captures the EX payload, runs one data-memory
// transaction per load/store with a bus timeout, and presents the write-back payload.
module kamus_mem
    import kamus_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [5:0]  operation_i,
    input  logic [31:0] ex_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] next_pc_i,
    input  logic [1:0]  wb_mux_sel_i,
    input  logic        l1d_wr_en_i,
    input  logic        regfile_wr_en_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic        wb_valid_o,
    output logic [31:0] wb_ex_o,
    output logic [31:0] wb_load_data_o,
    output logic [4:0]  wb_rd_addr_o,
    output logic [31:0] wb_next_pc_o,
    output logic [1:0]  wb_mux_sel_o,
    output logic        wb_regfile_wr_en_o,
    output logic        exc_misaligned_o,
    output logic        exc_bus_err_o
);

    localparam int               CNT_W    = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_TIMEOUT - 1);

    mem_state_e       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [5:0]       op_q;
    logic             regfile_wr_en_q;
    logic [31:0]      load_data;
    logic             capture;
    logic             mem_access;
    logic             misaligned;
    logic             done;
    logic             timeout;

    assign capture    = valid_i && (state == MEM_IDLE);
    assign mem_access = is_load(operation_i) || is_store(operation_i);
    assign misaligned = is_misaligned(operation_i, ex_i[1:0]);

    // A response only counts once the request has been granted, possibly in the same cycle.
    assign done    = dmem_rvalid_i && ((state == MEM_RESP) || ((state == MEM_REQ) && dmem_gnt_i));
    assign timeout = (state != MEM_IDLE) && !done && (cycle_cnt == CNT_LAST);

    kamus_load_align u_load_align (
        .operation (op_q),
        .addr_lo   (wb_ex_o[1:0]),
        .rdata     (dmem_rdata_i),
        .load_data (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= MEM_IDLE;
            cycle_cnt          <= '0;
            op_q               <= 6'h00;
            regfile_wr_en_q    <= 1'b0;
            stall_o            <= 1'b0;
            dmem_req_o         <= 1'b0;
            dmem_we_o          <= 1'b0;
            dmem_addr_o        <= 32'h0;
            dmem_be_o          <= 4'h0;
            dmem_wdata_o       <= 32'h0;
            wb_valid_o         <= 1'b0;
            wb_ex_o            <= 32'h0;
            wb_load_data_o     <= 32'h0;
            wb_rd_addr_o       <= 5'h0;
            wb_next_pc_o       <= 32'h0;
            wb_mux_sel_o       <= 2'h0;
            wb_regfile_wr_en_o <= 1'b0;
            exc_misaligned_o   <= 1'b0;
            exc_bus_err_o      <= 1'b0;
        end else begin
            wb_valid_o         <= 1'b0;
            wb_regfile_wr_en_o <= 1'b0;
            exc_misaligned_o   <= 1'b0;
            exc_bus_err_o      <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (capture) begin
                        op_q            <= operation_i;
                        regfile_wr_en_q <= regfile_wr_en_i;
                        wb_ex_o         <= ex_i;
                        wb_rd_addr_o    <= rd_addr_i;
                        wb_next_pc_o    <= next_pc_i;
                        wb_mux_sel_o    <= wb_mux_sel_i;
                        dmem_we_o       <= l1d_wr_en_i;
                        dmem_addr_o     <= {ex_i[31:2], 2'b00};
                        dmem_be_o       <= byte_enable(operation_i, ex_i[1:0]);
                        dmem_wdata_o    <= store_data(operation_i, rs2_data_i);
                        cycle_cnt       <= '0;
                        if (mem_access && !misaligned) begin
                            state      <= MEM_REQ;
                            stall_o    <= 1'b1;
                            dmem_req_o <= 1'b1;
                        end else begin
                            wb_valid_o         <= 1'b1;
                            exc_misaligned_o   <= misaligned;
                            wb_regfile_wr_en_o <= regfile_wr_en_i && !misaligned;
                        end
                    end
                end
                MEM_REQ, MEM_RESP: begin
                    if (done) begin
                        state              <= MEM_IDLE;
                        stall_o            <= 1'b0;
                        dmem_req_o         <= 1'b0;
                        wb_valid_o         <= 1'b1;
                        exc_bus_err_o      <= dmem_err_i;
                        wb_regfile_wr_en_o <= regfile_wr_en_q && !dmem_err_i;
                        wb_load_data_o     <= load_data;
                    end else if (timeout) begin
                        state         <= MEM_IDLE;
                        stall_o       <= 1'b0;
                        dmem_req_o    <= 1'b0;
                        wb_valid_o    <= 1'b1;
                        exc_bus_err_o <= 1'b1;
                    end else begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                        if ((state == MEM_REQ) && dmem_gnt_i) begin
                            state      <= MEM_RESP;
                            dmem_req_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= MEM_IDLE;
                    stall_o    <= 1'b0;
                    dmem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kamus_mem.sv
// Self-checking bench for kamus_mem: directed loads/stores/ALU ops against an
// arithmetic model of the write-back payload and the data-memory request.
module tb_kamus_mem;
    import kamus_pkg::*;

    localparam int BUS_TIMEOUT = 4;

    logic        clk_i, rst_ni, valid_i;
    logic [5:0]  operation_i;
    logic [31:0] ex_i, rs2_data_i, next_pc_i;
    logic [4:0]  rd_addr_i;
    logic [1:0]  wb_mux_sel_i;
    logic        l1d_wr_en_i, regfile_wr_en_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] wb_ex_o, wb_load_data_o, wb_next_pc_o;
    logic [4:0]  wb_rd_addr_o;
    logic [1:0]  wb_mux_sel_o;
    logic        wb_regfile_wr_en_o, exc_misaligned_o, exc_bus_err_o;

    typedef struct {
        logic [31:0] ex;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [1:0]  sel;
        logic        rf;
        logic        mis;
        logic        berr;
        logic        chk_ld;
        logic [31:0] ld;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   stall_cnt = 0;

    kamus_mem #(.BUS_TIMEOUT(BUS_TIMEOUT)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .valid_i            (valid_i),
        .operation_i        (operation_i),
        .ex_i               (ex_i),
        .rs2_data_i         (rs2_data_i),
        .rd_addr_i          (rd_addr_i),
        .next_pc_i          (next_pc_i),
        .wb_mux_sel_i       (wb_mux_sel_i),
        .l1d_wr_en_i        (l1d_wr_en_i),
        .regfile_wr_en_i    (regfile_wr_en_i),
        .stall_o            (stall_o),
        .dmem_req_o         (dmem_req_o),
        .dmem_we_o          (dmem_we_o),
        .dmem_addr_o        (dmem_addr_o),
        .dmem_be_o          (dmem_be_o),
        .dmem_wdata_o       (dmem_wdata_o),
        .dmem_gnt_i         (dmem_gnt_i),
        .dmem_rvalid_i      (dmem_rvalid_i),
        .dmem_rdata_i       (dmem_rdata_i),
        .dmem_err_i         (dmem_err_i),
        .wb_valid_o         (wb_valid_o),
        .wb_ex_o            (wb_ex_o),
        .wb_load_data_o     (wb_load_data_o),
        .wb_rd_addr_o       (wb_rd_addr_o),
        .wb_next_pc_o       (wb_next_pc_o),
        .wb_mux_sel_o       (wb_mux_sel_o),
        .wb_regfile_wr_en_o (wb_regfile_wr_en_o),
        .exc_misaligned_o   (exc_misaligned_o),
        .exc_bus_err_o      (exc_bus_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic int access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Take the addressed field as a number modulo its span, then fold to negative for signed loads.
    function automatic logic [31:0] model_load(input logic [5:0] op, input int off, input logic [31:0] rdata);
        longint span, v;
        span = longint'(1) << (8 * access_size(op));
        v    = longint'(rdata >> (8 * off)) % span;
        if ((op == OP_LB || op == OP_LH) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] ex);
        int size;
        size = access_size(op);
        if (op_is_load(op) || size == 4) return 4'hF;
        return 4'(((1 << size) - 1) << (ex % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [5:0] op, input logic [31:0] rs2);
        case (access_size(op))
            1:       return (rs2 & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (rs2 & 32'h0000_FFFF) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic exp_t model_expect(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] rdata,
                                          input logic err, input logic timed_out);
        exp_t e;
        int   size;
        size     = access_size(op);
        e.ex     = ex;
        e.rd     = ex[6:2];
        e.pc     = ex + 32'd4;
        e.sel    = op_is_load(op) ? WB_SEL_LOAD : WB_SEL_EX;
        e.mis    = (size != 0) && ((ex % size) != 0);
        e.berr   = (size != 0) && !e.mis && (err || timed_out);
        e.rf     = !op_is_store(op) && !e.mis && !e.berr;
        e.chk_ld = op_is_load(op) && !e.mis && !e.berr;
        e.ld     = e.chk_ld ? model_load(op, int'(ex % 4), rdata) : 32'h0;
        return e;
    endfunction

    task automatic drive_payload(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] rs2);
        valid_i         = 1'b1;
        operation_i     = op;
        ex_i            = ex;
        rs2_data_i      = rs2;
        rd_addr_i       = ex[6:2];
        next_pc_i       = ex + 32'd4;
        wb_mux_sel_i    = op_is_load(op) ? WB_SEL_LOAD : WB_SEL_EX;
        l1d_wr_en_i     = op_is_store(op);
        regfile_wr_en_i = !op_is_store(op);
    endtask

    // Every cycle with a write-back pulse must match the oldest expectation; otherwise exceptions stay low.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            if (stall_o) stall_cnt++;
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL spurious_wb: wb_valid_o=1, expected 0");
                end else begin
                    e = exp_q.pop_front();
                    check("wb_ex", wb_ex_o, e.ex);
                    check("wb_rd_addr", 32'(wb_rd_addr_o), 32'(e.rd));
                    check("wb_next_pc", wb_next_pc_o, e.pc);
                    check("wb_mux_sel", 32'(wb_mux_sel_o), 32'(e.sel));
                    check("wb_regfile_wr_en", 32'(wb_regfile_wr_en_o), 32'(e.rf));
                    check("exc_misaligned", 32'(exc_misaligned_o), 32'(e.mis));
                    check("exc_bus_err", 32'(exc_bus_err_o), 32'(e.berr));
                    if (e.chk_ld) check("wb_load_data", wb_load_data_o, e.ld);
                end
            end else begin
                check("exc_quiet", 32'({exc_misaligned_o, exc_bus_err_o, wb_regfile_wr_en_o}), 32'd0);
            end
        end
    end

    // resp_delay: 0 = rvalid with gnt, n>0 = rvalid n cycles after gnt, <0 = never (timeout).
    task automatic apply_stimulus(input logic [5:0] op, input logic [31:0] ex, input logic [31:0] rs2,
                                  input logic [31:0] rdata, input logic err, input int gnt_delay,
                                  input int resp_delay, input logic stray, input int exp_stall);
        exp_t e;
        int   waited;
        e = model_expect(op, ex, rdata, err, resp_delay < 0);
        stall_cnt = 0;
        drive_payload(op, ex, rs2);
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        valid_i     = 1'b0;
        operation_i = OP_NOP;
        if (access_size(op) != 0 && !e.mis) begin
            for (int k = 0; k <= gnt_delay; k++) begin
                check("dmem_req", 32'(dmem_req_o), 32'd1);
                check("dmem_addr", dmem_addr_o, ex & 32'hFFFF_FFFC);
                check("dmem_be", 32'(dmem_be_o), 32'(model_be(op, ex)));
                check("dmem_we", 32'(dmem_we_o), 32'(op_is_store(op)));
                if (op_is_store(op)) check("dmem_wdata", dmem_wdata_o, model_wdata(op, rs2));
                dmem_gnt_i    = (k == gnt_delay);
                dmem_rvalid_i = ((k == gnt_delay) && (resp_delay == 0)) || (stray && k == 0 && gnt_delay > 0);
                dmem_rdata_i  = rdata;
                dmem_err_i    = dmem_rvalid_i && ((k == gnt_delay) ? err : 1'b1);
                @(posedge clk_i); #1;
                dmem_gnt_i    = 1'b0;
                dmem_rvalid_i = 1'b0;
                dmem_err_i    = 1'b0;
            end
            if (resp_delay > 0) begin
                repeat (resp_delay - 1) begin
                    @(posedge clk_i); #1;
                end
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
                dmem_err_i    = err;
                @(posedge clk_i); #1;
                dmem_rvalid_i = 1'b0;
                dmem_err_i    = 1'b0;
            end
            waited = 0;
            while (stall_o && waited < 300) begin
                @(posedge clk_i); #1;
                waited++;
            end
            check("stall_release", 32'(stall_o), 32'd0);
        end else begin
            check("no_req", 32'(dmem_req_o), 32'd0);
            check("no_stall", 32'(stall_o), 32'd0);
        end
        @(posedge clk_i); #1;
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        check("wb_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_stall"}, 32'(stall_o), 32'd0);
        check({pfx, "_req"}, 32'(dmem_req_o), 32'd0);
        check({pfx, "_we"}, 32'(dmem_we_o), 32'd0);
        check({pfx, "_be"}, 32'(dmem_be_o), 32'd0);
        check({pfx, "_addr"}, dmem_addr_o, 32'd0);
        check({pfx, "_wdata"}, dmem_wdata_o, 32'd0);
        check({pfx, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
        check({pfx, "_wb_rf"}, 32'(wb_regfile_wr_en_o), 32'd0);
        check({pfx, "_exc"}, 32'({exc_misaligned_o, exc_bus_err_o}), 32'd0);
        check({pfx, "_wb_ex"}, wb_ex_o, 32'd0);
        check({pfx, "_wb_ld"}, wb_load_data_o, 32'd0);
        check({pfx, "_wb_misc"}, {wb_next_pc_o[24:0], wb_rd_addr_o, wb_mux_sel_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_ni        = 1'b1;
        valid_i       = 1'b0;
        operation_i   = OP_NOP;
        ex_i          = 32'h0;
        rs2_data_i    = 32'h0;
        rd_addr_i     = 5'h0;
        next_pc_i     = 32'h0;
        wb_mux_sel_i  = 2'h0;
        l1d_wr_en_i   = 1'b0;
        regfile_wr_en_i = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        dmem_err_i    = 1'b0;
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_values("rst_init");
        rst_ni = 1'b1;

        check("model_lh_lit", model_load(OP_LH, 2, 32'h8001_0000), 32'hFFFF_8001);
        check("model_lhu_lit", model_load(OP_LHU, 2, 32'h8001_0000), 32'h0000_8001);
        check("model_sb_be_lit", 32'(model_be(OP_SB, 32'h103)), 32'h8);
        check("model_sb_wdata_lit", model_wdata(OP_SB, 32'hAB), 32'hABAB_ABAB);

        apply_stimulus(OP_ADD, 32'h1234, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        check("add_wb_ex_lit", wb_ex_o, 32'h1234);

        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            logic [5:0] bop;
            bop = (i == 0) ? OP_SUB : (i == 1) ? OP_XOR : OP_LUI;
            drive_payload(bop, 32'h2000 + 32'(i * 52), 32'h0);
            exp_q.push_back(model_expect(bop, 32'h2000 + 32'(i * 52), 32'h0, 1'b0, 1'b0));
            @(posedge clk_i); #1;
            check("b2b_no_stall", 32'(stall_o), 32'd0);
        end
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        apply_stimulus(OP_SB, 32'h103, 32'hAB, 32'h0, 1'b0, 2, 1, 1'b1, 4);
        check("sb_be_lit", 32'(dmem_be_o), 32'h8);
        check("sb_wdata_lit", dmem_wdata_o, 32'hABAB_ABAB);
        check("sb_addr_lit", dmem_addr_o, 32'h100);
        apply_stimulus(OP_SH, 32'h102, 32'h1234_CDEF, 32'h0, 1'b0, 0, 2, 1'b0, 3);
        apply_stimulus(OP_SW, 32'h200, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 1, 1'b0, 3);

        apply_stimulus(OP_LH, 32'h102, 32'h0, 32'h8001_0000, 1'b0, 0, 0, 1'b0, 1);
        check("lh_lit", wb_load_data_o, 32'hFFFF_8001);
        apply_stimulus(OP_LHU, 32'h102, 32'h0, 32'h8001_0000, 1'b0, 0, 0, 1'b0, 1);
        check("lhu_lit", wb_load_data_o, 32'h0000_8001);
        apply_stimulus(OP_LB, 32'h101, 32'h0, 32'h1234_F680, 1'b0, 0, 0, 1'b0, 1);
        apply_stimulus(OP_LBU, 32'h103, 32'h0, 32'h7F00_0000, 1'b0, 1, 0, 1'b0, 2);
        apply_stimulus(OP_LW, 32'h104, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 1, 1'b0, 2);

        apply_stimulus(OP_LW, 32'h101, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        apply_stimulus(OP_SH, 32'h101, 32'h5555, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        apply_stimulus(OP_LHU, 32'h103, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 0);

        apply_stimulus(OP_LW, 32'h108, 32'h0, 32'h1111_2222, 1'b1, 0, 1, 1'b0, 2);

        apply_stimulus(OP_LW, 32'h10C, 32'h0, 32'h0, 1'b0, 0, -1, 1'b0, BUS_TIMEOUT);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h9999_9999;
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        check("late_rvalid_no_wb", 32'(wb_valid_o), 32'd0);
        check("late_rvalid_no_stall", 32'(stall_o), 32'd0);

        drive_payload(OP_LW, 32'h300, 32'h0);
        @(posedge clk_i); #1;
        valid_i    = 1'b0;
        dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        dmem_gnt_i = 1'b0;
        check("pre_reset_busy", 32'(stall_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        apply_stimulus(OP_LW, 32'h300, 32'h0, 32'h1357_9BDF, 1'b0, 0, 1, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
